// File: rtl/shift_reg_serdes.sv
// rtl/shift_reg_serdes.sv - bidirectional serial/parallel shift register with programmable bit order
// Deserializes WIDTH bits into a held word, or streams a loaded word out one bit per cycle.
module shift_reg_serdes #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             mode_in,
  input  logic             serial_in,
  input  logic             wr_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_in,
  input  logic             en_in,
  input  logic             hold_in,
  output logic             input_rdy,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             serial_out,
  output logic             serial_valid
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IN  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT_IN, FULL, SHIFT_OUT} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sr;

  logic [WIDTH-1:0] sr_capture;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] sr_rest;
  logic             load_bit;
  logic             sr_bit;

  // Capture shifts toward the end that the first bit must finally occupy;
  // serialize always emits from the opposite end of that same ordering.
  always_comb begin
    sr_capture = LSB_FIRST ? {serial_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], serial_in};
    load_bit   = LSB_FIRST ? parallel_in[0] : parallel_in[WIDTH-1];
    load_rest  = LSB_FIRST ? (parallel_in >> 1) : (parallel_in << 1);
    sr_bit     = LSB_FIRST ? sr[0] : sr[WIDTH-1];
    sr_rest    = LSB_FIRST ? (sr >> 1) : (sr << 1);
  end

  assign input_rdy = (state == IDLE) || (state == SHIFT_IN);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      count        <= '0;
      sr           <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mode_in) begin
            if (load_in) begin
              // First bit is registered straight from parallel_in so it shows the next cycle.
              serial_out   <= load_bit;
              serial_valid <= 1'b1;
              sr           <= load_rest;
              count        <= CW'(1);
              state        <= SHIFT_OUT;
            end
          end else if (wr_in) begin
            sr    <= sr_capture;
            count <= CW'(1);
            state <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (wr_in) begin
            sr <= sr_capture;
            if (count == LAST_IN) begin
              parallel_out <= sr_capture;
              out_valid    <= 1'b1;
              count        <= '0;
              state        <= FULL;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        FULL: begin
          if (en_in) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        SHIFT_OUT: begin
          if (!hold_in) begin
            if (count == LAST_OUT) begin
              serial_out   <= 1'b0;
              serial_valid <= 1'b0;
              count        <= '0;
              state        <= IDLE;
            end else begin
              serial_out <= sr_bit;
              sr         <= sr_rest;
              count      <= count + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_serdes.sv
// tb/tb_shift_reg_serdes.sv - self-checking bench for shift_reg_serdes
// Instance a is LSB-first, instance b is MSB-first; both are WIDTH=16.
module tb_shift_reg_serdes;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mode, sin, wr, load, en, hold;
  logic [W-1:0] pin, pout;
  logic irdy, ovalid, sout, svalid;

  logic b_rst, b_mode, b_sin, b_wr, b_load, b_en, b_hold;
  logic [W-1:0] b_pin, b_pout;
  logic b_irdy, b_ovalid, b_sout, b_svalid;

  int tests = 0;
  int fails = 0;

  shift_reg_serdes #(.WIDTH(W), .LSB_FIRST(1'b1)) u_a (
    .clk_in(clk), .rst_in(rst), .mode_in(mode), .serial_in(sin), .wr_in(wr),
    .parallel_in(pin), .load_in(load), .en_in(en), .hold_in(hold),
    .input_rdy(irdy), .parallel_out(pout), .out_valid(ovalid),
    .serial_out(sout), .serial_valid(svalid)
  );

  shift_reg_serdes #(.WIDTH(W), .LSB_FIRST(1'b0)) u_b (
    .clk_in(clk), .rst_in(b_rst), .mode_in(b_mode), .serial_in(b_sin), .wr_in(b_wr),
    .parallel_in(b_pin), .load_in(b_load), .en_in(b_en), .hold_in(b_hold),
    .input_rdy(b_irdy), .parallel_out(b_pout), .out_valid(b_ovalid),
    .serial_out(b_sout), .serial_valid(b_svalid)
  );

  task automatic idle_inputs();
    rst = 0; mode = 0; sin = 0; wr = 0; load = 0; en = 0; hold = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; b_rst = 1; wr = 1; load = 1; mode = 1; en = 1; pin = 16'hFFFF;
    @(negedge clk);
    idle_inputs(); b_rst = 0;
    tests++; if (irdy !== 1'b1) begin fails++; $display("FAIL reset_input_rdy: got %b want 1", irdy); end
    tests++; if (ovalid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", ovalid); end
    tests++; if (pout !== 16'h0) begin fails++; $display("FAIL reset_parallel_out: got %h want 0000", pout); end
    tests++; if (svalid !== 1'b0) begin fails++; $display("FAIL reset_serial_valid: got %b want 0", svalid); end
    tests++; if (sout !== 1'b0) begin fails++; $display("FAIL reset_serial_out: got %b want 0", sout); end
    tests++; if (b_irdy !== 1'b1 || b_ovalid !== 1'b0 || b_pout !== 16'h0) begin
      fails++; $display("FAIL reset_b: got rdy=%b valid=%b out=%h want 1 0 0000", b_irdy, b_ovalid, b_pout);
    end
  endtask

  task automatic test_deser_basic();
    logic [W-1:0] w;
    w = 16'hABCD;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests++; if (irdy !== 1'b1 || ovalid !== 1'b0 || pout !== 16'h0) begin
          fails++; $display("FAIL basic_in_progress bit %0d: got rdy=%b valid=%b out=%h want 1 0 0000", i + 1, irdy, ovalid, pout);
        end
      end
      wr = 1; sin = w[i];
    end
    @(negedge clk);
    wr = 0;
    tests++; if (ovalid !== 1'b1) begin fails++; $display("FAIL basic_out_valid: got %b want 1", ovalid); end
    tests++; if (pout !== w) begin fails++; $display("FAIL basic_word: got %h want %h", pout, w); end
    tests++; if (irdy !== 1'b0) begin fails++; $display("FAIL basic_full_rdy: got %b want 0", irdy); end
    en = 1;
    @(negedge clk);
    en = 0;
    tests++; if (ovalid !== 1'b0 || irdy !== 1'b1 || pout !== w) begin
      fails++; $display("FAIL basic_ack: got valid=%b rdy=%b out=%h want 0 1 %h", ovalid, irdy, pout, w);
    end
  endtask

  task automatic test_deserialize();
    logic [W-1:0] w;
    logic [1:0] stim[$];
    for (int n = 0; n < 6; n++) begin
      w = (n == 0) ? 16'h6789 : 16'($urandom);
      stim.delete();
      for (int i = 0; i < W; i++) begin
        stim.push_back({1'b1, w[i]});
        if (i < W - 1) begin
          int gap;
          gap = (n == 0) ? ((i == 3 || i == 10) ? 3 : 0) : int'($urandom_range(0, 2));
          for (int g = 0; g < gap; g++) stim.push_back({1'b0, 1'($urandom)});
        end
      end
      for (int j = 0; j < stim.size(); j++) begin
        @(negedge clk);
        if (j > 0) begin
          tests++; if (irdy !== 1'b1 || ovalid !== 1'b0) begin
            fails++; $display("FAIL gap_progress word %0d step %0d: got rdy=%b valid=%b want 1 0", n, j, irdy, ovalid);
          end
        end
        wr = stim[j][1]; sin = stim[j][0];
      end
      for (int f = 0; f < 3; f++) begin
        @(negedge clk);
        tests++; if (ovalid !== 1'b1 || irdy !== 1'b0 || pout !== w) begin
          fails++; $display("FAIL gap_full word %0d: got valid=%b rdy=%b out=%h want 1 0 %h", n, ovalid, irdy, pout, w);
        end
        wr = 1; sin = 1'($urandom); load = 1'($urandom);
      end
      @(negedge clk);
      wr = 0; load = 0; en = 1;
      @(negedge clk);
      en = 0;
      tests++; if (ovalid !== 1'b0 || irdy !== 1'b1 || pout !== w) begin
        fails++; $display("FAIL gap_ack word %0d: got valid=%b rdy=%b out=%h want 0 1 %h", n, ovalid, irdy, pout, w);
      end
    end
  endtask

  // Continuous wr_in with a consumer that acknowledges one cycle after seeing out_valid.
  task automatic test_back_to_back();
    logic [W-1:0] cur;
    logic b;
    int o;
    cur = '0;
    for (int c = 0; c <= 18 * 3; c++) begin
      @(negedge clk);
      o = c % 18;
      if (c > 0 && o == 16) begin
        tests++; if (ovalid !== 1'b1 || irdy !== 1'b0 || pout !== cur) begin
          fails++; $display("FAIL b2b_word cycle %0d: got valid=%b rdy=%b out=%h want 1 0 %h", c, ovalid, irdy, pout, cur);
        end
      end
      if (c > 0 && o == 0) begin
        tests++; if (ovalid !== 1'b0 || irdy !== 1'b1) begin
          fails++; $display("FAIL b2b_restart cycle %0d: got valid=%b rdy=%b want 0 1", c, ovalid, irdy);
        end
      end
      if (c == 18 * 3) break;
      b = 1'($urandom);
      wr = 1; sin = b; en = (o == 17);
      if (o < 16) cur[o] = b;
    end
    wr = 0; en = 0;
  endtask

  task automatic test_serialize();
    logic [W-1:0] w;
    int idx, nvalid, nhold;
    bit h, done;
    for (int k = 0; k < 6; k++) begin
      w = (k < 2) ? 16'h6789 : 16'($urandom);
      @(negedge clk);
      mode = 1; load = 1; pin = w;
      idx = 0; nvalid = 0; nhold = 0; done = 0;
      for (int c = 0; c < W + 12; c++) begin
        @(negedge clk);
        load = 0; pin = 16'($urandom);
        if (idx < W) begin
          tests++; if (svalid !== 1'b1 || sout !== w[idx] || irdy !== 1'b0) begin
            fails++; $display("FAIL ser_bit case %0d idx %0d: got valid=%b bit=%b rdy=%b want 1 %b 0", k, idx, svalid, sout, irdy, w[idx]);
          end
          nvalid++;
          if (k == 0) h = 0;
          else if (k == 1) h = (idx == 4 && nhold < 2);
          else h = ($urandom_range(0, 3) == 0 && nhold < 4);
          nhold += int'(h);
          hold = h;
          if (!h) idx++;
        end else begin
          tests++; if (svalid !== 1'b0 || sout !== 1'b0 || irdy !== 1'b1) begin
            fails++; $display("FAIL ser_end case %0d: got valid=%b bit=%b rdy=%b want 0 0 1", k, svalid, sout, irdy);
          end
          hold = 0; done = 1;
          break;
        end
      end
      tests++; if (!done || nvalid != W + nhold) begin
        fails++; $display("FAIL ser_length case %0d: got %0d valid cycles done=%0d want %0d", k, nvalid, done, W + nhold);
      end
      if (k == 1) begin
        tests++; if (nvalid != 18) begin fails++; $display("FAIL ser_hold_total: got %0d want 18", nvalid); end
      end
      mode = 0; hold = 0;
    end
  endtask

  task automatic test_idle_rules();
    logic [W-1:0] w;
    w = 16'($urandom);
    @(negedge clk);
    mode = 0; load = 1; pin = w;
    @(negedge clk);
    load = 0;
    tests++; if (svalid !== 1'b0 || irdy !== 1'b1) begin
      fails++; $display("FAIL idle_load_mode0: got valid=%b rdy=%b want 0 1", svalid, irdy);
    end
    mode = 1; wr = 1; sin = 1;
    @(negedge clk);
    tests++; if (svalid !== 1'b0 || irdy !== 1'b1) begin
      fails++; $display("FAIL idle_wr_mode1: got valid=%b rdy=%b want 0 1", svalid, irdy);
    end
    load = 1; pin = w;
    @(negedge clk);
    load = 0; wr = 0;
    tests++; if (svalid !== 1'b1 || sout !== w[0] || irdy !== 1'b0) begin
      fails++; $display("FAIL idle_load_wins: got valid=%b bit=%b rdy=%b want 1 %b 0", svalid, sout, irdy, w[0]);
    end
    for (int i = 1; i <= W; i++) @(negedge clk);
    tests++; if (svalid !== 1'b0 || irdy !== 1'b1 || ovalid !== 1'b0) begin
      fails++; $display("FAIL idle_drain: got valid=%b rdy=%b ovalid=%b want 0 1 0", svalid, irdy, ovalid);
    end
    mode = 0;
  endtask

  task automatic test_mode_toggle();
    logic [W-1:0] w, w2, w3;
    w = 16'($urandom); w2 = 16'($urandom); w3 = 16'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      mode = (i == 0) ? 1'b0 : 1'($urandom);
      load = (i == 0) ? 1'b0 : 1'($urandom);
      pin = 16'($urandom); wr = 1; sin = w[i];
    end
    @(negedge clk);
    wr = 0;
    tests++; if (ovalid !== 1'b1 || pout !== w) begin
      fails++; $display("FAIL toggle_deser: got valid=%b out=%h want 1 %h", ovalid, pout, w);
    end
    en = 1; mode = 1; load = 1; pin = w2;
    @(negedge clk);
    en = 0;
    tests++; if (ovalid !== 1'b0 || svalid !== 1'b0 || irdy !== 1'b1) begin
      fails++; $display("FAIL toggle_full_load: got valid=%b svalid=%b rdy=%b want 0 0 1", ovalid, svalid, irdy);
    end
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      tests++; if (svalid !== 1'b1 || sout !== w2[i]) begin
        fails++; $display("FAIL toggle_ser idx %0d: got valid=%b bit=%b want 1 %b", i, svalid, sout, w2[i]);
      end
      mode = 1'($urandom); wr = 1'($urandom); load = 1'($urandom); sin = 1'($urandom); pin = 16'($urandom);
    end
    @(negedge clk);
    tests++; if (svalid !== 1'b0 || irdy !== 1'b1) begin
      fails++; $display("FAIL toggle_ser_end: got valid=%b rdy=%b want 0 1", svalid, irdy);
    end
    load = 0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      mode = 0; wr = 1; sin = w3[i];
    end
    @(negedge clk);
    wr = 0;
    tests++; if (ovalid !== 1'b1 || pout !== w3) begin
      fails++; $display("FAIL toggle_new_mode: got valid=%b out=%h want 1 %h", ovalid, pout, w3);
    end
    en = 1;
    @(negedge clk);
    en = 0;
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] w;
    w = 16'h1234;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      mode = 0; wr = 1; sin = 1;
    end
    @(negedge clk);
    rst = 1; en = 1; load = 1;
    @(negedge clk);
    rst = 0; en = 0; load = 0; wr = 0;
    tests++; if (irdy !== 1'b1 || ovalid !== 1'b0 || pout !== 16'h0) begin
      fails++; $display("FAIL mid_reset: got rdy=%b valid=%b out=%h want 1 0 0000", irdy, ovalid, pout);
    end
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      wr = 1; sin = w[i];
    end
    @(negedge clk);
    wr = 0;
    tests++; if (ovalid !== 1'b1 || pout !== w) begin
      fails++; $display("FAIL mid_reset_next: got valid=%b out=%h want 1 %h", ovalid, pout, w);
    end
    en = 1;
    @(negedge clk);
    en = 0; mode = 1; load = 1; pin = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      load = 0;
    end
    rst = 1;
    @(negedge clk);
    rst = 0; mode = 0;
    tests++; if (svalid !== 1'b0 || sout !== 1'b0 || irdy !== 1'b1) begin
      fails++; $display("FAIL mid_reset_ser: got valid=%b bit=%b rdy=%b want 0 0 1", svalid, sout, irdy);
    end
  endtask

  task automatic test_msb_first();
    logic [W-1:0] w, exp_w;
    logic bits[W];
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < W; i++) bits[i] = (n == 0) ? (i == 0 || i == W - 1) : 1'($urandom);
      exp_w = '0;
      for (int i = 0; i < W; i++) exp_w[W-1-i] = bits[i];
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        b_mode = 0; b_wr = 1; b_sin = bits[i];
      end
      @(negedge clk);
      b_wr = 0;
      tests++; if (b_ovalid !== 1'b1 || b_pout !== exp_w) begin
        fails++; $display("FAIL msb_deser %0d: got valid=%b out=%h want 1 %h", n, b_ovalid, b_pout, exp_w);
      end
      if (n == 0) begin
        tests++; if (b_pout !== 16'h8001) begin fails++; $display("FAIL msb_8001: got %h want 8001", b_pout); end
      end
      b_en = 1;
      @(negedge clk);
      b_en = 0;
    end
    for (int n = 0; n < 2; n++) begin
      w = (n == 0) ? 16'h4000 : 16'($urandom);
      b_mode = 1; b_load = 1; b_pin = w;
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        b_load = 0;
        tests++; if (b_svalid !== 1'b1 || b_sout !== w[W-1-i]) begin
          fails++; $display("FAIL msb_ser %0d idx %0d: got valid=%b bit=%b want 1 %b", n, i, b_svalid, b_sout, w[W-1-i]);
        end
      end
      @(negedge clk);
      b_mode = 0;
      tests++; if (b_svalid !== 1'b0) begin fails++; $display("FAIL msb_ser_end %0d: got %b want 0", n, b_svalid); end
    end
  endtask

  initial begin
    idle_inputs(); rst = 1; pin = '0;
    b_rst = 1; b_mode = 0; b_sin = 0; b_wr = 0; b_load = 0; b_en = 0; b_hold = 0; b_pin = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_deser_basic();
    test_deserialize();
    test_back_to_back();
    test_serialize();
    test_idle_rules();
    test_mode_toggle();
    test_reset_mid_word();
    test_msb_first();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
